// File: rtl/load_store_unit_pkg.sv
// Shared constants for the load/store unit: RV32I width codes, FSM encoding,
// byte-enable patterns and the access-decode helpers used by the datapath.
package load_store_unit_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } lsuState_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic isIllegal(input logic we, input logic [2:0] funct3,
                                     input logic [1:0] addrLo);
    logic bad;
    case (funct3)
      FUNCT3_LB, FUNCT3_LBU: bad = 1'b0;
      FUNCT3_LH, FUNCT3_LHU: bad = addrLo[0];
      FUNCT3_LW:             bad = (addrLo != 2'b00);
      default:               bad = 1'b1;
    endcase
    // Unsigned widths only make sense for loads.
    if (we && funct3[2]) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [3:0] byteEnable(input logic [2:0] funct3, input logic [1:0] addrLo);
    logic [3:0] be;
    case (funct3)
      FUNCT3_LB, FUNCT3_LBU: be = BE_BYTE << addrLo;
      FUNCT3_LH, FUNCT3_LHU: be = BE_HALF << {addrLo[1], 1'b0};
      default:               be = BE_WORD;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] writeData(input logic [2:0] funct3, input logic [31:0] data);
    logic [31:0] wd;
    case (funct3[1:0])
      2'b00:   wd = {4{data[7:0]}};
      2'b01:   wd = {2{data[15:0]}};
      default: wd = data;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// load_align_extend: shifts the addressed lane of a bus word down to bit 0
// and sign- or zero-extends it according to the RV32I width code.
module load_align_extend
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rawWord,
  input  logic [1:0]  addrLo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rawWord >> {addrLo, 3'b000};
    case (funct3)
      FUNCT3_LB:  result = {{24{shifted[7]}}, shifted[7:0]};
      FUNCT3_LH:  result = {{16{shifted[15]}}, shifted[15:0]};
      FUNCT3_LBU: result = {24'h000000, shifted[7:0]};
      FUNCT3_LHU: result = {16'h0000, shifted[15:0]};
      default:    result = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one execute-stage request into a single data-bus
// transaction with registered strobes, lanes and aligned/extended read data.
//
// state  | meaning
// IDLE   | waiting for iReq; decodes legality at acceptance
// ACCESS | one cycle with strobe, address, byte enables and write data driven
// WAIT   | load only; down-counts MEM_LATENCY-1..0, captures read data at 0
// DONE   | one-cycle oDone pulse, oFault reports an illegal access
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  input  logic                  iReq,
  input  logic                  iWe,
  input  logic [2:0]            iFunct3,
  input  logic [ADDR_WIDTH-1:0] iAddr,
  input  logic [31:0]           iStoreData,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oFault,
  output logic [31:0]           oLoadData,
  output logic                  oMemRead,
  output logic                  oMemWrite,
  output logic [3:0]            oMemByteEnable,
  output logic [ADDR_WIDTH-1:0] oMemAddress,
  output logic [31:0]           oMemWriteData,
  input  logic [31:0]           iMemReadData
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(MEM_LATENCY - 1);

  lsuState_t        state;
  logic             weR;
  logic [2:0]       funct3R;
  logic [1:0]       addrLoR;
  logic [CNT_W-1:0] waitCnt;
  logic [31:0]      loadExt;

  load_align_extend uAlign (
    .rawWord (iMemReadData),
    .addrLo  (addrLoR),
    .funct3  (funct3R),
    .result  (loadExt)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state          <= ST_IDLE;
      weR            <= 1'b0;
      funct3R        <= 3'b000;
      addrLoR        <= 2'b00;
      waitCnt        <= '0;
      oBusy          <= 1'b0;
      oDone          <= 1'b0;
      oFault         <= 1'b0;
      oLoadData      <= 32'h0;
      oMemRead       <= 1'b0;
      oMemWrite      <= 1'b0;
      oMemByteEnable <= 4'b0000;
      oMemAddress    <= '0;
      oMemWriteData  <= 32'h0;
    end else begin
      // Bus fields are only driven during ACCESS; every other state parks them at 0.
      oDone          <= 1'b0;
      oFault         <= 1'b0;
      oMemRead       <= 1'b0;
      oMemWrite      <= 1'b0;
      oMemByteEnable <= 4'b0000;
      oMemAddress    <= '0;
      oMemWriteData  <= 32'h0;
      case (state)
        ST_IDLE: begin
          if (iReq) begin
            weR     <= iWe;
            funct3R <= iFunct3;
            addrLoR <= iAddr[1:0];
            oBusy   <= 1'b1;
            if (isIllegal(iWe, iFunct3, iAddr[1:0])) begin
              state  <= ST_DONE;
              oDone  <= 1'b1;
              oFault <= 1'b1;
            end else begin
              state          <= ST_ACCESS;
              oMemRead       <= ~iWe;
              oMemWrite      <= iWe;
              oMemByteEnable <= byteEnable(iFunct3, iAddr[1:0]);
              oMemAddress    <= {iAddr[ADDR_WIDTH-1:2], 2'b00};
              oMemWriteData  <= writeData(iFunct3, iStoreData);
            end
          end
        end
        ST_ACCESS: begin
          if (weR) begin
            state <= ST_DONE;
            oDone <= 1'b1;
          end else begin
            state   <= ST_WAIT;
            waitCnt <= CNT_START;
          end
        end
        ST_WAIT: begin
          if (waitCnt == '0) begin
            oLoadData <= loadExt;
            state     <= ST_DONE;
            oDone     <= 1'b1;
          end else begin
            waitCnt <= waitCnt - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          oBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Core-side initiator for the data-memory bus: turns one load/store request from the execute stage into a single bus transaction.
- Generates the word-aligned address, byte enables and replicated write data; captures, aligns and sign/zero-extends read data.
- Detects misaligned or illegal accesses before driving the bus.
- Sits between the pipeline and the data memory interface, which responds on the bus one memory-clock later.

Parameters:
- MEM_LATENCY, 1, cycles from read-strobe cycle to the cycle in which iMemReadData is valid; must be >= 1.
- ADDR_WIDTH, 32, width of request and bus addresses.

Ports:
- iCLK  in  1  core clock.
- iRST_N  in  1  asynchronous active-low reset.
- iReq  in  1  request valid; sampled only in IDLE.
- iWe  in  1  1 = store, 0 = load.
- iFunct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- iAddr  in  ADDR_WIDTH  byte address.
- iStoreData  in  32  store source (rs2).
- oBusy  out  1  high whenever state != IDLE.
- oDone  out  1  one-cycle completion pulse.
- oFault  out  1  valid with oDone; misaligned/illegal access.
- oLoadData  out  32  extended load result; held until next oDone.
- oMemRead  out  1  read strobe.
- oMemWrite  out  1  write strobe.
- oMemByteEnable  out  4  byte lanes.
- oMemAddress  out  ADDR_WIDTH  {iAddr[31:2],2'b00}.
- oMemWriteData  out  32  lane-replicated store data.
- iMemReadData  in  32  bus read data.

Behaviour:
- Reset (async, iRST_N=0): state IDLE; all outputs 0 (oLoadData 0). Reset mid-transaction aborts it immediately, with no oDone and strobes dropped asynchronously.
- All outputs are registered; no input-to-output combinational path.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - iReq=1 latches iWe, iFunct3, iAddr and iStoreData.
  - If illegal, go to DONE with the fault flag set and no bus activity.
  - Otherwise go to ACCESS.
  - iReq while oBusy=1 is ignored, not queued.
- Illegal access:
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - funct3 in {011,110,111}.
  - Store with funct3[2]=1.
- ACCESS: exactly one cycle.
  - oMemRead=~we, oMemWrite=we; address, byte enables and write data valid.
  - Store: go to DONE. Load: go to WAIT.
- Byte enables:
  - B/BU: 0001<<addr[1:0].
  - H/HU: 0011<<{addr[1],1'b0}.
  - W: 1111.
  - Loads drive the same enables as stores.
- Write data:
  - B: {4{d[7:0]}}.
  - H: {2{d[15:0]}}.
  - W: d.
- WAIT:
  - Counter from MEM_LATENCY-1 down to 0; strobes low throughout.
  - On the count==0 edge, capture iMemReadData >> (8*addr[1:0]), then extend: B/H sign-extend bit 7/15, BU/HU zero-extend.
  - Then go to DONE.
- DONE: oDone=1 for one cycle; oFault=1 if illegal, else 0; next state IDLE. A new request can be accepted on the following cycle.
- Latency, with request accepted at edge 0:
  - Store: oDone in cycle 2.
  - Load: oDone in cycle 2+MEM_LATENCY.
  - Fault: oDone in cycle 1.
- oLoadData updates only on successful loads. Stores and faults leave it unchanged.
- Unused upper address bits pass through unchanged; no range check (the responder decodes the range).

Decomposition:
- Shared package / config.v constants:
  - funct3 width codes (FUNCT3_LB..FUNCT3_LHU).
  - LSU state encoding (2-bit).
  - Byte-enable patterns.
- One combinational sub-module, load_align_extend:
  - Inputs: raw word, addr[1:0], funct3.
  - Output: 32-bit extended result.
  - Reused by the bench as a reference model.

Test Plan:
- SW addr 0x10010004, data 0xDEADBEEF -> in ACCESS: oMemWrite=1, BE=1111, oMemAddress=0x10010004, WD=0xDEADBEEF; oDone in cycle 2, oFault=0.
- SB addr 0x10010003, data 0x000000A5 -> BE=1000, WD=0xA5A5A5A5, address 0x10010000.
- LB addr 0x10010002, memory word 0x12F03456 -> oLoadData=0xFFFFFFF0; LBU on the same word -> 0x000000F0; oDone at cycle 3 with MEM_LATENCY=1.
- LH addr 0x10010001 -> no strobes, oDone in cycle 1 with oFault=1, oLoadData unchanged; likewise SW addr 0x...2, and funct3=011.
- Back-to-back: iReq held high across two loads -> second accepted only after DONE, one strobe per transaction; MEM_LATENCY=3 load -> oDone in cycle 5.
- Assert iRST_N=0 during WAIT -> all outputs 0 asynchronously, no oDone; a next request after release completes normally.
